gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_chk_pkg.sv | 34 +++
 rtl/gate_chk_vec_gen.sv | 52 +++++
 rtl/gate_checker.sv | 119 +++++++++++
 tb/tb_gate_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate checker.
// Truth tables are indexed by {a,b}: bit idx holds the expected output for that vector.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;

  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam logic [1:0]  LAST_IDX   = 2'd3;
  localparam logic [2:0]  ERR_MAX    = 3'd4;

  function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

  // Out-of-range settle values are pulled back into 1..15 so the run always terminates.
  function automatic logic [3:0] settle_load(input int unsigned settle);
    if (settle < SETTLE_MIN) return 4'(SETTLE_MIN);
    if (settle > SETTLE_MAX) return 4'(SETTLE_MAX);
    return 4'(settle);
  endfunction

endpackage

// File: rtl/gate_chk_vec_gen.sv
// Vector generator: owns the vector index, the settle down-counter and the a/b decode.
// The FSM tells it when a run starts, when it is driving and when a sample step completes.
module gate_chk_vec_gen
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_drive,
  input  logic       i_advance,
  output logic [1:0] o_idx,
  output logic       o_settle_tc,
  output logic       o_last,
  output logic       o_a,
  output logic       o_b
);

  localparam logic [3:0] SETTLE_LD = settle_load(SETTLE);

  logic [1:0] r_idx;
  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_idx <= 2'd0;
      r_cnt <= SETTLE_LD;
    end else if (i_drive) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end else if (i_advance) begin
      // Leaving the last vector parks the index at 0 so IDLE drives a=b=0.
      if (r_idx == LAST_IDX) begin
        r_idx <= 2'd0;
        r_cnt <= 4'd0;
      end else begin
        r_idx <= r_idx + 2'd1;
        r_cnt <= SETTLE_LD;
      end
    end
  end

  assign o_idx       = r_idx;
  assign o_settle_tc = (r_cnt == 4'd1);
  assign o_last      = (r_idx == LAST_IDX);
  assign o_a         = r_idx[1];
  assign o_b         = r_idx[0];

endmodule

// File: rtl/gate_checker.sv
// Exhaustive two-input gate checker: steps {a,b} through 00,01,10,11, samples y after a
// settle window and scores it against TRUTH.
//
// state  | meaning
// IDLE   | waiting for start, a=b=0, results held
// DRIVE  | vector idx applied, settle counter running
// SAMPLE | compare y against TRUTH[idx], then advance or finish
// DONE   | one-cycle done pulse, pass valid
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = OR_TT,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_cnt;
  logic [3:0] r_fail_vec;

  logic [1:0] w_idx;
  logic       w_settle_tc;
  logic       w_last;
  logic       w_load;
  logic       w_drive;
  logic       w_advance;
  logic       w_expect;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_drive   = (r_state == ST_DRIVE);
  assign w_advance = (r_state == ST_SAMPLE);
  assign w_expect  = tt_bit(TRUTH, w_idx);

  gate_chk_vec_gen #(
    .SETTLE (SETTLE)
  ) u_vec_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_drive     (w_drive),
    .i_advance   (w_advance),
    .o_idx       (w_idx),
    .o_settle_tc (w_settle_tc),
    .o_last      (w_last),
    .o_a         (a),
    .o_b         (b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= 3'd0;
      r_fail_vec <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_DRIVE;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_err_cnt  <= 3'd0;
            r_fail_vec <= 4'd0;
          end
        end
        ST_DRIVE: begin
          if (w_settle_tc) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          // An X/Z on y makes the equality unknown, which falls into the mismatch branch.
          if (y == w_expect) begin
            if (w_last) r_pass <= (r_err_cnt == 3'd0);
          end else begin
            if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 3'd1;
            r_fail_vec[w_idx] <= 1'b1;
            r_pass            <= 1'b0;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (OR/SETTLE=1, OR/SETTLE=3, AND/SETTLE=1), each
// wired to a bench-side gate whose truth table can be changed between runs.
module tb_gate_checker;
  import gate_chk_pkg::*;

  localparam logic [3:0] TT_P [3] = '{OR_TT, OR_TT, AND_TT};
  localparam int         ST_P [3] = '{1, 3, 1};

  logic       clk;
  logic       rst_n;
  logic       start    [3];
  logic       a        [3];
  logic       b        [3];
  logic       y        [3];
  logic       busy     [3];
  logic       done     [3];
  logic       pass     [3];
  logic [2:0] err_cnt  [3];
  logic [3:0] fail_vec [3];
  logic [3:0] gtt      [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign y[g] = gtt[g][{a[g], b[g]}];
    gate_checker #(
      .TRUTH  (TT_P[g]),
      .SETTLE (ST_P[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .a        (a[g]),
      .b        (b[g]),
      .y        (y[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .err_cnt  (err_cnt[g]),
      .fail_vec (fail_vec[g])
    );
  end

  typedef struct {
    int         dut;
    logic [3:0] gate;
    logic [2:0] err;
    logic [3:0] fv;
    logic       pass;
    bit         poke;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected scores come straight from the difference of the two truth tables.
  task automatic model(input int d, input logic [3:0] g, output logic [2:0] e_err,
                       output logic [3:0] e_fv, output logic e_pass);
    logic [3:0] diff;
    diff   = TT_P[d] ^ g;
    e_fv   = diff;
    e_err  = 3'($countones(diff));
    e_pass = (diff == 4'd0);
  endtask

  // Accepts a run on DUT d and checks the full cycle-by-cycle schedule and final score.
  task automatic run_check(input int d, input logic [2:0] e_err, input logic [3:0] e_fv,
                           input logic e_pass, input bit hold, input bit poke);
    int s, lim, vec;
    s   = ST_P[d];
    lim = 4 * (s + 1);
    start[d] = 1'b1;
    tick();
    chk("clear_at_accept", {pass[d], err_cnt[d], fail_vec[d]}, 8'd0);
    for (int k = 1; k <= lim; k++) begin
      vec = (k - 1) / (s + 1);
      chk($sformatf("sched d%0d k%0d", d, k), {a[d], b[d], busy[d], done[d]},
          {vec[1:0], 1'b1, 1'b0});
      start[d] = hold ? 1'b1 : (poke && (k % 3 == 0) && (k < lim));
      tick();
    end
    chk($sformatf("done_pulse d%0d", d), {busy[d], done[d]}, 2'b01);
    chk($sformatf("err_cnt d%0d", d), err_cnt[d], e_err);
    chk($sformatf("fail_vec d%0d", d), fail_vec[d], e_fv);
    chk($sformatf("pass d%0d", d), pass[d], e_pass);
    start[d] = hold;
    tick();
    chk($sformatf("after_done d%0d", d), {busy[d], done[d], a[d], b[d]}, 4'b0000);
    chk($sformatf("hold_result d%0d", d), {pass[d], err_cnt[d], fail_vec[d]},
        {e_pass, e_err, e_fv});
  endtask

  initial begin
    logic [2:0] m_err;
    logic [3:0] m_fv;
    logic       m_pass;
    logic [3:0] g;

    tbl[0] = '{0, 4'b1110, 3'd0, 4'b0000, 1'b1, 1'b0};
    tbl[1] = '{0, 4'b0000, 3'd3, 4'b1110, 1'b0, 1'b0};
    tbl[2] = '{0, 4'b0110, 3'd1, 4'b1000, 1'b0, 1'b0};
    tbl[3] = '{0, 4'b0001, 3'd4, 4'b1111, 1'b0, 1'b0};
    tbl[4] = '{0, 4'b1111, 3'd1, 4'b0001, 1'b0, 1'b0};
    tbl[5] = '{0, 4'b1000, 3'd2, 4'b0110, 1'b0, 1'b0};
    tbl[6] = '{2, 4'b1110, 3'd2, 4'b0110, 1'b0, 1'b0};
    tbl[7] = '{1, 4'b1110, 3'd0, 4'b0000, 1'b1, 1'b1};
    tbl[8] = '{1, 4'b0000, 3'd3, 4'b1110, 1'b0, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      gtt[i]   = OR_TT;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset d%0d", i),
          {a[i], b[i], busy[i], done[i], pass[i], err_cnt[i], fail_vec[i]}, 12'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      gtt[tbl[i].dut] = tbl[i].gate;
      run_check(tbl[i].dut, tbl[i].err, tbl[i].fv, tbl[i].pass, 1'b0, tbl[i].poke);
      repeat (2) tick();
      chk($sformatf("no_restart row%0d", i), {busy[tbl[i].dut], done[tbl[i].dut]}, 2'b00);
    end

    for (int i = 0; i < 16; i++) begin
      int d;
      d = (i % 4 == 3) ? 2 : 0;
      g = 4'($urandom_range(0, 15));
      gtt[d] = g;
      model(d, g, m_err, m_fv, m_pass);
      run_check(d, m_err, m_fv, m_pass, 1'b0, 1'b0);
      tick();
    end

    // Reset four cycles into a run with a vector-0 mismatch already scored.
    gtt[0]   = NOR_TT;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    chk("pre_reset_err", err_cnt[0], 3'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_reset", {a[0], b[0], busy[0], done[0], pass[0], err_cnt[0], fail_vec[0]}, 12'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("aborted k%0d", k), {busy[0], done[0]}, 2'b00);
      tick();
    end
    gtt[0] = OR_TT;
    run_check(0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();

    // start held high: second run is accepted at the end of the cycle after done.
    gtt[0] = 4'b0000;
    run_check(0, 3'd3, 4'b1110, 1'b0, 1'b1, 1'b0);
    gtt[0] = OR_TT;
    run_check(0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
